// File: rtl/sevseg_arbiter.sv
// Round-robin arbiter that shares a two-digit hex display between NREQ requesters.
// Each grant latches the winner's byte and holds it on DIGIT1:DIGIT0 for HOLD_CYCLES clocks.
`timescale 1ns/1ps
module sevseg_arbiter #(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned HOLD_CYCLES = 12000000,
  localparam int unsigned OWNER_W    = (NREQ > 2) ? $clog2(NREQ) : 1
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [NREQ-1:0]     REQ,
  input  logic [8*NREQ-1:0]   VALUE,
  output logic [NREQ-1:0]     GNT,
  output logic [3:0]          DIGIT0,
  output logic [3:0]          DIGIT1,
  output logic                BUSY,
  output logic [OWNER_W-1:0]  OWNER
);

  localparam int unsigned CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic {IDLE, SHOW} state_t;

  state_t               state_q, state_d;
  logic [OWNER_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NREQ-1:0]      gnt_d;
  logic [3:0]           dig0_d, dig1_d;
  logic                 busy_d;
  logic [OWNER_W-1:0]   owner_d;

  logic                 found_c;
  logic [OWNER_W-1:0]   win_c;
  logic [OWNER_W-1:0]   idx_c;
  logic [7:0]           sel_c;
  logic                 take_c;

  // Rotating search starting just after the last granted requester
  always_comb begin : pick
    found_c = 1'b0;
    win_c   = '0;
    idx_c   = '0;
    for (int i = 1; i <= int'(NREQ); i++) begin
      idx_c = OWNER_W'((int'(ptr_q) + i) % int'(NREQ));
      if (!found_c && REQ[idx_c]) begin
        found_c = 1'b1;
        win_c   = idx_c;
      end
    end
  end

  always_comb begin : value_mux
    sel_c = '0;
    for (int j = 0; j < int'(NREQ); j++) begin
      if (win_c == OWNER_W'(j)) sel_c = VALUE[8*j +: 8];
    end
  end

  always_comb begin : next
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt_d   = '0;
    dig0_d  = DIGIT0;
    dig1_d  = DIGIT1;
    busy_d  = BUSY;
    owner_d = OWNER;
    take_c  = 1'b0;

    case (state_q)
      IDLE: take_c = found_c;
      SHOW: begin
        if (cnt_q == '0) begin
          if (found_c) begin
            take_c = 1'b1;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // A grant opens a fresh window; the display is frozen until it expires
    if (take_c) begin
      state_d = SHOW;
      gnt_d   = NREQ'(1) << win_c;
      dig0_d  = sel_c[3:0];
      dig1_d  = sel_c[7:4];
      busy_d  = 1'b1;
      owner_d = win_c;
      ptr_d   = win_c;
      cnt_d   = CNT_W'(HOLD_CYCLES - 1);
    end
  end

  always_ff @(posedge CLK) begin : regs
    if (RST) begin
      state_q <= IDLE;
      ptr_q   <= OWNER_W'(NREQ - 1);
      cnt_q   <= '0;
      GNT     <= '0;
      DIGIT0  <= '0;
      DIGIT1  <= '0;
      BUSY    <= 1'b0;
      OWNER   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      GNT     <= gnt_d;
      DIGIT0  <= dig0_d;
      DIGIT1  <= dig1_d;
      BUSY    <= busy_d;
      OWNER   <= owner_d;
    end
  end

endmodule

// File: tb/tb_sevseg_arbiter.sv
// Directed bench for sevseg_arbiter with NREQ=4, HOLD_CYCLES=4.
`timescale 1ns/1ps
module tb_sevseg_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned HOLD = 4;

  logic              CLK = 1'b0;
  logic              RST;
  logic [NREQ-1:0]   REQ;
  logic [8*NREQ-1:0] VALUE;
  logic [NREQ-1:0]   GNT;
  logic [3:0]        DIGIT0, DIGIT1;
  logic              BUSY;
  logic [1:0]        OWNER;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] rr_val [4];

  always #5 CLK = ~CLK;

  sevseg_arbiter #(.NREQ(NREQ), .HOLD_CYCLES(HOLD)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .VALUE(VALUE), .GNT(GNT),
    .DIGIT0(DIGIT0), .DIGIT1(DIGIT1), .BUSY(BUSY), .OWNER(OWNER)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Packed observation: {GNT, DIGIT1, DIGIT0, BUSY, OWNER}
  task automatic expect_out(input string tag, input logic [3:0] gnt, input logic [7:0] disp,
                            input logic busy, input logic [1:0] owner);
    check(tag, {17'b0, GNT, DIGIT1, DIGIT0, BUSY, OWNER}, {17'b0, gnt, disp, busy, owner});
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    rr_val[0] = 8'h10; rr_val[1] = 8'h21; rr_val[2] = 8'h32; rr_val[3] = 8'h43;

    // Reset with random activity on the inputs
    RST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      REQ   = 4'($urandom);
      VALUE = 32'($urandom);
      tick;
      expect_out($sformatf("reset%0d", i), 4'b0000, 8'h00, 1'b0, 2'd0);
    end
    RST = 1'b0;
    REQ = '0;
    tick;
    expect_out("idle_after_reset", 4'b0000, 8'h00, 1'b0, 2'd0);

    // Single request from requester 2
    REQ = 4'b0100;
    VALUE = '0;
    VALUE[23:16] = 8'hA7;
    tick;
    expect_out("single_grant", 4'b0100, 8'hA7, 1'b1, 2'd2);
    REQ = '0;
    for (int c = 1; c < int'(HOLD); c++) begin
      tick;
      expect_out($sformatf("single_hold%0d", c), 4'b0000, 8'hA7, 1'b1, 2'd2);
    end
    tick;
    expect_out("single_expire", 4'b0000, 8'hA7, 1'b0, 2'd2);

    // Round robin from a fresh reset: 0,1,2,3,0 back-to-back
    RST = 1'b1;
    tick;
    expect_out("reset_pre_rr", 4'b0000, 8'h00, 1'b0, 2'd0);
    RST = 1'b0;
    REQ = 4'b1111;
    VALUE = {8'h43, 8'h32, 8'h21, 8'h10};
    for (int w = 0; w < 5; w++) begin
      for (int c = 0; c < int'(HOLD); c++) begin
        tick;
        expect_out($sformatf("rr_w%0d_c%0d", w, c), (c == 0) ? 4'(1 << (w % 4)) : 4'b0000,
                   rr_val[w % 4], 1'b1, 2'(w % 4));
      end
    end
    REQ = '0;
    tick;
    expect_out("rr_drain", 4'b0000, 8'h10, 1'b0, 2'd0);

    // Freeze: VALUE and REQ changes during SHOW are ignored until expiry
    REQ = 4'b0010;
    VALUE[15:8] = 8'h5C;
    tick;
    expect_out("freeze_grant", 4'b0010, 8'h5C, 1'b1, 2'd1);
    REQ = 4'b1000;
    VALUE[15:8]  = 8'hFF;
    VALUE[31:24] = 8'h9E;
    for (int c = 1; c < int'(HOLD); c++) begin
      tick;
      expect_out($sformatf("freeze_hold%0d", c), 4'b0000, 8'h5C, 1'b1, 2'd1);
    end
    tick;
    expect_out("freeze_next_grant", 4'b1000, 8'h9E, 1'b1, 2'd3);
    REQ = '0;
    for (int c = 1; c < int'(HOLD); c++) tick;
    tick;
    expect_out("freeze_idle", 4'b0000, 8'h9E, 1'b0, 2'd3);

    // Withdrawn request: requester 1 drops before being served
    REQ = 4'b0011;
    VALUE[7:0]  = 8'h66;
    VALUE[15:8] = 8'h77;
    tick;
    expect_out("wd_grant0", 4'b0001, 8'h66, 1'b1, 2'd0);
    REQ = '0;
    for (int c = 1; c < int'(HOLD); c++) begin
      tick;
      expect_out($sformatf("wd_hold%0d", c), 4'b0000, 8'h66, 1'b1, 2'd0);
    end
    tick;
    expect_out("wd_expire", 4'b0000, 8'h66, 1'b0, 2'd0);
    tick;
    expect_out("wd_stay_idle", 4'b0000, 8'h66, 1'b0, 2'd0);

    // Reset in the middle of a window
    REQ = 4'b0001;
    VALUE[7:0] = 8'h55;
    tick;
    expect_out("mid_grant", 4'b0001, 8'h55, 1'b1, 2'd0);
    REQ = '0;
    tick;
    expect_out("mid_hold1", 4'b0000, 8'h55, 1'b1, 2'd0);
    RST = 1'b1;
    tick;
    expect_out("mid_reset", 4'b0000, 8'h00, 1'b0, 2'd0);
    RST = 1'b0;
    REQ = 4'b1000;
    VALUE[31:24] = 8'hBD;
    tick;
    expect_out("post_reset_grant3", 4'b1000, 8'hBD, 1'b1, 2'd3);
    REQ = '0;
    for (int c = 1; c < int'(HOLD); c++) tick;
    tick;
    expect_out("post_reset_idle", 4'b0000, 8'hBD, 1'b0, 2'd3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sevseg_arbiter.md
Name: sevseg_arbiter

Overview:
Shares the two-digit 7-segment Pmod display between NREQ independent requesters. Each requester offers an 8-bit value. The block grants requesters in round-robin order and latches the granted value. It then holds that value on the display for HOLD_CYCLES clocks. DIGIT0/DIGIT1 drive the 4-bit hex inputs of the existing two-digit multiplexed sevseg driver; the arbiter sits between user logic and that driver.

Parameters:
NREQ, 4, number of requesters (2..8)
HOLD_CYCLES, 12000000, display hold time per grant in CLK cycles (>=1; 1 s at 12 MHz)
OWNER_W, max(1,clog2(NREQ)), width of OWNER (derived, not overridden)

Ports:
CLK  input  1  system clock, all logic on rising edge
RST  input  1  synchronous reset, active-high
REQ  input  NREQ  REQ[i] high = requester i wants display; held until GNT[i]
VALUE  input  8*NREQ  VALUE[8*i+7:8*i] = byte of requester i; low nibble -> DIGIT0, high nibble -> DIGIT1
GNT  output  NREQ  one-cycle grant pulse, one-hot or zero
DIGIT0  output  4  low hex digit to sevseg driver
DIGIT1  output  4  high hex digit to sevseg driver
BUSY  output  1  high while a hold window is running
OWNER  output  OWNER_W  index of requester currently/last displayed

Behaviour:
- All outputs registered.
- Reset: GNT=0, DIGIT0=0, DIGIT1=0, BUSY=0, OWNER=0, state=IDLE, hold counter=0.
- Reset sets the round-robin pointer so requester 0 has top priority on the first grant.
- RST has priority over every other input. RST asserted mid-hold aborts the window immediately; the next cycle shows reset values.
- States: IDLE, SHOW.
- Arbitration: search starts at (last_owner+1) mod NREQ, wraps, and picks the first i with REQ[i]=1. After reset, last_owner = NREQ-1.
- IDLE, |REQ=0: stay IDLE. Outputs hold; DIGIT0/DIGIT1 keep the last displayed value and are never blanked.
- IDLE, |REQ=1 at edge k: at edge k the block does the following:
  - GNT[w]=1 for one cycle;
  - DIGIT1:DIGIT0 = VALUE slice w;
  - OWNER=w;
  - BUSY=1;
  - hold counter = HOLD_CYCLES-1;
  - state -> SHOW.
  - Latency REQ->GNT/display is 1 cycle.
- SHOW: GNT=0. The counter decrements each cycle. REQ and VALUE changes are ignored, and the displayed value is frozen.
- SHOW, counter=0:
  - if |REQ=1, arbitrate on the same edge. This is a back-to-back grant with no idle cycle; BUSY stays 1 and the new window starts.
  - else BUSY=0, state -> IDLE.
- Each grant therefore displays its value for exactly HOLD_CYCLES cycles, measured from the GNT cycle.
- HOLD_CYCLES=1: each window is one cycle. Continuous requests yield a grant every cycle, rotating.
- Requester protocol:
  - REQ may drop in the cycle after GNT.
  - If REQ stays high after GNT, it is a new request and competes in round robin.
  - REQ dropped before grant is silently withdrawn; no error flag.
- Only the granted requester's VALUE is sampled, and only on the grant edge.
- Fairness: with all REQ continuously high, grant order is 0,1,...,NREQ-1,0,... No requester waits more than NREQ-1 windows.
- The pointer advances only on a grant.

Test Plan:
All scenarios use NREQ=4, HOLD_CYCLES=4.
- Reset: RST=1 for 3 cycles with random REQ/VALUE -> GNT=0000, DIGIT0=0, DIGIT1=0, BUSY=0, OWNER=0 on every cycle after the first reset edge.
- Single request: REQ=0100, VALUE[23:16]=8'hA7 at edge k -> GNT=0100 for one cycle, DIGIT1=A, DIGIT0=7, OWNER=2, BUSY=1 for cycles k..k+3. Release REQ after GNT -> BUSY=0 at k+4, display still A7.
- Round robin: REQ=1111 held, slices 8'h10,8'h21,8'h32,8'h43 -> grants 0,1,2,3,0 every 4 cycles, back-to-back. Display 10,21,32,43,10; BUSY never drops.
- Freeze during SHOW: grant requester 1 with 8'h5C, then change VALUE[15:8] to 8'hFF and assert REQ[3] mid-window -> display stays 5C for exactly 4 cycles. Requester 3 is then granted on the expiry edge.
- Withdrawn request: REQ=0011, REQ[1] dropped while requester 0 is in SHOW -> after expiry no GNT[1]. State returns to IDLE, BUSY=0, display holds requester 0 value.
- Reset mid-window: RST pulsed at cycle 2 of a SHOW -> next cycle shows reset values. A following REQ=1000 is granted with OWNER=3 within 1 cycle of RST deassertion.
